// File: rtl/com_pkg.sv
// Shared types and widths for the centroid tracker.
//   rot_t       : quadrant / rotation code
//   trk_state_t : tracker FSM state
//   X_W, Y_W    : centroid coordinate widths
package com_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  typedef enum logic [1:0] {
    ROT_TOP    = 2'b00,
    ROT_BOTTOM = 2'b01,
    ROT_RIGHT  = 2'b10,
    ROT_LEFT   = 2'b11
  } rot_t;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } trk_state_t;

endpackage

// File: rtl/com_tracker_ema_filter.sv
// ema_filter: one-axis exponential moving average register.
// Ports:
//   clk, rst_n : clock, async active-low reset (value clears to 0)
//   load       : q <= din (raw acquisition)
//   update     : q <= q + ((din - q) >>> ALPHA_SHIFT), floor rounding
//   din        : new sample
//   dout       : filtered value
// load has priority over update.
module ema_filter #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned ALPHA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             update,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0]        q;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        next;

  // Difference is one bit wider and signed; the arithmetic shift floors.
  // The true result lies between q and din, so truncation never wraps.
  always_comb begin
    diff = $signed({1'b0, din}) - $signed({1'b0, q});
    next = WIDTH'($signed({1'b0, q}) + (diff >>> ALPHA_SHIFT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (update) begin
      q <= next;
    end
  end

  assign dout = q;

endmodule

// File: rtl/com_tracker.sv
// com_tracker: smooths centroid coordinates, debounces the rotation code and
// tracks lock based on per-frame sample presence.
// Ports:
//   clk_in, rst_in        : clock, async active-low reset
//   x_in, y_in, rotate_in : centroid sample, qualified by valid_in
//   frame_in              : end-of-frame strobe
//   x_out, y_out          : filtered coordinates
//   rotate_out            : debounced rotation
//   valid_out             : one cycle after each valid_in
//   rotate_change_out     : with valid_out when a debounced commit occurs
//   locked_out            : high while tracking
// Config macro: COM_TRACKER_SMOOTH_EN enables EMA smoothing in TRACK;
// otherwise coordinates are passed through raw.
module com_tracker
  import com_pkg::*;
#(
  parameter int unsigned CONFIRM_COUNT = 3,
  parameter int unsigned LOST_FRAMES   = 8,
  parameter int unsigned ALPHA_SHIFT   = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [1:0]     rotate_in,
  input  logic           valid_in,
  input  logic           frame_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [1:0]     rotate_out,
  output logic           valid_out,
  output logic           rotate_change_out,
  output logic           locked_out
);

  localparam logic [3:0] CONFIRM_C = CONFIRM_COUNT[3:0];
  localparam logic [7:0] LOST_C    = LOST_FRAMES[7:0];

  trk_state_t state_q, state_d;
  rot_t       rot_q, cand_q, rot_new;
  logic [3:0] cnt_q, cnt_next;
  logic [7:0] miss_q, miss_inc;
  logic       seen_q;
  logic       valid_q, chg_q;
  logic       commit;
  logic       filt_load, filt_update;

  always_comb begin
    rot_new  = rot_t'(rotate_in);
    cnt_next = (rot_new == cand_q) ? cnt_q + 4'd1 : 4'd1;
    commit   = (rot_new != rot_q) && (cnt_next >= CONFIRM_C);
    miss_inc = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ST_SEARCH;
    else         state_q <= state_d;
  end

  // A frame only counts as a miss if no sample arrived since the last frame;
  // a sample in the same cycle as frame_in belongs to the closing frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: if (valid_in) state_d = ST_TRACK;
      ST_TRACK:  if (frame_in && !valid_in && !seen_q && miss_inc >= LOST_C)
                   state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rot_q   <= ROT_TOP;
      cand_q  <= ROT_TOP;
      cnt_q   <= '0;
      miss_q  <= '0;
      seen_q  <= 1'b0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      if (state_q == ST_SEARCH) begin
        if (valid_in) begin
          rot_q   <= rot_new;
          cand_q  <= ROT_TOP;
          cnt_q   <= '0;
          miss_q  <= '0;
          seen_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end else if (valid_in) begin
        valid_q <= 1'b1;
        miss_q  <= '0;
        seen_q  <= ~frame_in;
        if (rot_new == rot_q) begin
          cnt_q <= '0;
        end else if (commit) begin
          rot_q  <= rot_new;
          cand_q <= rot_new;
          cnt_q  <= '0;
          chg_q  <= 1'b1;
        end else begin
          cand_q <= rot_new;
          cnt_q  <= cnt_next;
        end
      end else if (frame_in) begin
        if (seen_q) seen_q <= 1'b0;
        else        miss_q <= miss_inc;
      end
    end
  end

`ifdef COM_TRACKER_SMOOTH_EN
  assign filt_load   = (state_q == ST_SEARCH) && valid_in;
  assign filt_update = (state_q == ST_TRACK) && valid_in;
`else
  assign filt_load   = valid_in;
  assign filt_update = 1'b0;
`endif

  ema_filter #(.WIDTH(X_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_x (
    .clk(clk_in), .rst_n(rst_in), .load(filt_load), .update(filt_update),
    .din(x_in), .dout(x_out)
  );

  ema_filter #(.WIDTH(Y_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema_y (
    .clk(clk_in), .rst_n(rst_in), .load(filt_load), .update(filt_update),
    .din(y_in), .dout(y_out)
  );

  assign rotate_out        = rot_q;
  assign valid_out         = valid_q;
  assign rotate_change_out = chg_q;
  assign locked_out        = (state_q == ST_TRACK);

endmodule

// File: tb/tb_com_tracker.sv
// Bench for com_tracker: a behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_com_tracker;

  localparam int CONFIRM = 3;
  localparam int LOST    = 8;
  localparam int ASH     = 2;
`ifdef COM_TRACKER_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic [1:0]  rotate_in = '0;
  logic        valid_in = 1'b0;
  logic        frame_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [1:0]  rotate_out;
  logic        valid_out, rotate_change_out, locked_out;

  int checks = 0;
  int failures = 0;

  com_tracker #(.CONFIRM_COUNT(CONFIRM), .LOST_FRAMES(LOST), .ALPHA_SHIFT(ASH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .rotate_in(rotate_in), .valid_in(valid_in), .frame_in(frame_in),
    .x_out(x_out), .y_out(y_out), .rotate_out(rotate_out),
    .valid_out(valid_out), .rotate_change_out(rotate_change_out),
    .locked_out(locked_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Floor division by 2^k on plain integers.
  function automatic int fdiv(input int d, input int k);
    int p;
    p = 1 << k;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  // Behavioural model
  bit m_track, m_vpend, m_chg, m_seen;
  int m_x, m_y, m_rot, m_cand, m_cnt, m_miss;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_track = 0; m_vpend = 0; m_chg = 0; m_seen = 0;
      m_x = 0; m_y = 0; m_rot = 0; m_cand = 0; m_cnt = 0; m_miss = 0;
    end else begin
      m_vpend = 0;
      m_chg = 0;
      if (!m_track) begin
        if (valid_in) begin
          m_x = x_in; m_y = y_in; m_rot = rotate_in;
          m_cand = 0; m_cnt = 0; m_miss = 0; m_seen = 1;
          m_track = 1; m_vpend = 1;
        end
      end else if (valid_in) begin
        if (SMOOTH) begin
          m_x = m_x + fdiv(int'(x_in) - m_x, ASH);
          m_y = m_y + fdiv(int'(y_in) - m_y, ASH);
        end else begin
          m_x = x_in;
          m_y = y_in;
        end
        if (int'(rotate_in) == m_rot) m_cnt = 0;
        else begin
          m_cnt = (int'(rotate_in) == m_cand) ? m_cnt + 1 : 1;
          m_cand = rotate_in;
          if (m_cnt >= CONFIRM) begin
            m_rot = rotate_in; m_cnt = 0; m_chg = 1;
          end
        end
        m_vpend = 1;
        m_miss = 0;
        m_seen = !frame_in;
      end else if (frame_in) begin
        if (m_seen) m_seen = 0;
        else begin
          if (m_miss < 255) m_miss = m_miss + 1;
          if (m_miss >= LOST) m_track = 0;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("m_valid", valid_out, m_vpend);
      chk("m_change", rotate_change_out, m_chg);
      chk("m_locked", locked_out, m_track);
      chk("m_x", x_out, m_x);
      chk("m_y", y_out, m_y);
      chk("m_rot", rotate_out, m_rot);
    end
  end

  task automatic send(input bit v, input bit f, input int x, input int y, input int r);
    @(posedge clk_in); #2;
    valid_in = v; frame_in = f;
    x_in = 11'(x); y_in = 10'(y); rotate_in = 2'(r);
    @(posedge clk_in); #2;
    valid_in = 0; frame_in = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #2;
    chk("rst_x", x_out, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_valid", valid_out, 0);
    rst_in = 1;

    // Acquisition
    send(1, 0, 400, 300, 0);
    chk("acq_valid", valid_out, 1);
    chk("acq_x", x_out, 400);
    chk("acq_y", y_out, 300);
    chk("acq_locked", locked_out, 1);

    // Smoothing / raw pass-through
    send(1, 0, 800, 300, 0);
    chk("ema_x1", x_out, SMOOTH ? 500 : 800);
    send(1, 0, 100, 300, 0);
    chk("ema_x2", x_out, SMOOTH ? 400 : 100);

    // Debounce: three agreeing samples commit
    send(1, 0, 100, 300, 2);
    chk("deb1_rot", rotate_out, 0);
    send(1, 0, 100, 300, 2);
    chk("deb2_rot", rotate_out, 0);
    send(1, 0, 100, 300, 2);
    chk("deb3_rot", rotate_out, 2);
    chk("deb3_chg", rotate_change_out, 1);
    // Back to 00
    for (int i = 0; i < 3; i++) send(1, 0, 100, 300, 0);
    chk("deb_back", rotate_out, 0);
    // Interleaved candidates never commit
    send(1, 0, 100, 300, 2);
    send(1, 0, 100, 300, 3);
    send(1, 0, 100, 300, 2);
    chk("deb_mix_rot", rotate_out, 0);
    chk("deb_mix_chg", rotate_change_out, 0);
    send(1, 0, 100, 300, 0);

    // Sample with every frame: lock retained
    for (int i = 0; i < 20; i++) send(1, 1, 120 + i, 200, 0);
    chk("frames_locked", locked_out, 1);

    // Eight empty frames drop lock on the eighth
    for (int i = 0; i < LOST - 1; i++) send(0, 1, 0, 0, 0);
    chk("lost7_locked", locked_out, 1);
    send(0, 1, 0, 0, 0);
    chk("lost8_locked", locked_out, 0);
    chk("lost8_valid", valid_out, 0);
    // SEARCH ignores frames
    for (int i = 0; i < 3; i++) send(0, 1, 0, 0, 0);
    chk("search_locked", locked_out, 0);
    // Re-acquire with a raw load
    send(1, 0, 50, 60, 0);
    chk("reacq_x", x_out, 50);
    chk("reacq_y", y_out, 60);
    chk("reacq_locked", locked_out, 1);

    // Reset while an update is in flight
    @(posedge clk_in); #2;
    valid_in = 1; x_in = 11'd900; y_in = 10'd800; rotate_in = 2'd1;
    @(negedge clk_in);
    rst_in = 0;
    @(posedge clk_in); #2;
    valid_in = 0;
    chk("rstmid_valid", valid_out, 0);
    chk("rstmid_x", x_out, 0);
    chk("rstmid_y", y_out, 0);
    chk("rstmid_rot", rotate_out, 0);
    chk("rstmid_locked", locked_out, 0);
    @(posedge clk_in); #2;
    chk("rstmid_valid2", valid_out, 0);
    rst_in = 1;
    send(1, 0, 7, 9, 1);
    chk("post_rst_x", x_out, 7);
    chk("post_rst_rot", rotate_out, 1);
    chk("post_rst_locked", locked_out, 1);

    repeat (3) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
